lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_bytefmt.sv | 41 ++++
 rtl/lsu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit and the main decoder.
//   lsu_state_t : FSM states of lsu_ctrl (IDLE, RD, WR, FIN)
//   MW_*        : memwrite encodings (load, word store, byte store; 11 is illegal)
//   LT_*        : ltype encodings (lw, lbu, lb; 11 is illegal)
//   lsu_illegal : flags a request whose memwrite or ltype uses the reserved code
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } lsu_state_t;

  localparam logic [1:0] MW_LOAD = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_BYTE = 2'b10;

  localparam logic [1:0] LT_W  = 2'b00;
  localparam logic [1:0] LT_BU = 2'b01;
  localparam logic [1:0] LT_B  = 2'b10;

  function automatic logic lsu_illegal(input logic [1:0] mw, input logic [1:0] lt);
    return (mw == 2'b11) || (lt == 2'b11);
  endfunction

endpackage

// File: rtl/lsu_bytefmt.sv
// lsu_bytefmt: combinational byte-lane formatter for lsu_ctrl.
// Lanes are little-endian: lane k occupies bits [8k+7:8k].
//   i_word  : word read from memory
//   i_lane  : byte lane (address bits [1:0])
//   i_ltype : load type (LT_W / LT_BU / LT_B)
//   i_byte  : store byte for the read-modify-write merge
//   o_load  : load result (whole word, or lane zero/sign-extended)
//   o_merge : i_word with the selected lane replaced by i_byte
module lsu_bytefmt
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_ltype,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0] w_lane;

  always_comb begin
    w_lane  = i_word[7:0];
    o_merge = i_word;
    case (i_lane)
      2'd0: begin w_lane = i_word[7:0];   o_merge[7:0]   = i_byte; end
      2'd1: begin w_lane = i_word[15:8];  o_merge[15:8]  = i_byte; end
      2'd2: begin w_lane = i_word[23:16]; o_merge[23:16] = i_byte; end
      default: begin w_lane = i_word[31:24]; o_merge[31:24] = i_byte; end
    endcase
  end

  always_comb begin
    case (i_ltype)
      LT_BU:   o_load = {24'h000000, w_lane};
      LT_B:    o_load = {{24{w_lane[7]}}, w_lane};
      default: o_load = i_word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller. Turns a one-cycle start pulse into a
// memory read and/or write handshake; byte stores are done as read-modify-write.
//   clk, reset            : clock (rising edge), asynchronous active-high reset
//   start                 : request pulse, ignored while busy
//   memwrite, ltype       : access kind (lsu_pkg MW_* / LT_*)
//   addr, wdata           : byte address and store data, captured at start
//   rdata                 : formatted load result, held until the next load completes
//   busy, done, fault     : in-flight flag, completion pulse, abort pulse (with done)
//   mem_req, mem_we       : memory request and write enable, held until mem_ack
//   mem_addr, mem_wdata   : word-aligned address and write data
//   mem_rdata, mem_ack    : memory read data and acknowledge
// Parameters: AW (address width), TIMEOUT_CYC (max ack wait cycles, 0 = none).
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned word accesses
// without touching memory; otherwise addr[1:0] is ignored for word accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int AW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    memwrite,
  input  logic [1:0]    ltype,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  lsu_state_t    r_state;
  lsu_state_t    w_state_nxt;
  logic          r_fault;
  logic          w_fault_nxt;
  logic [31:0]   r_wait;
  logic          w_timeout;
  logic          w_trap;
  logic [1:0]    r_mw;
  logic [1:0]    r_lt;
  logic [1:0]    r_lane;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [31:0]   w_load;
  logic [31:0]   w_merge;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (addr[1:0] != 2'b00) &&
                  ((memwrite == MW_WORD) || ((memwrite == MW_LOAD) && (ltype == LT_W)));
`else
  assign w_trap = 1'b0;
`endif

  // The wait counter is the cycle index within the current state, so the
  // last permitted cycle of a request is index TIMEOUT_CYC-1.
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_wait == TO_LAST);

  // State register; r_fault remembers why FIN was entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fault <= w_fault_nxt;
    end
  end

  // Next-state logic. An ack in the last allowed cycle wins over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_fault_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (lsu_illegal(memwrite, ltype) || w_trap) begin
            w_state_nxt = FIN;
            w_fault_nxt = 1'b1;
          end else if (memwrite == MW_WORD) begin
            w_state_nxt = WR;
          end else begin
            w_state_nxt = RD;
          end
        end
      end
      RD: begin
        if (mem_ack) begin
          w_state_nxt = (r_mw == MW_BYTE) ? WR : FIN;
        end else if (w_timeout) begin
          w_state_nxt = FIN;
          w_fault_nxt = 1'b1;
        end
      end
      WR: begin
        if (mem_ack) begin
          w_state_nxt = FIN;
        end else if (w_timeout) begin
          w_state_nxt = FIN;
          w_fault_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    fault   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (r_state)
      RD: begin
        busy    = 1'b1;
        mem_req = 1'b1;
      end
      WR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      FIN: begin
        busy  = 1'b1;
        done  = 1'b1;
        fault = r_fault;
      end
      default: ;
    endcase
  end

  // Wait counter: cleared on every state change, saturates otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= '0;
    end else if (w_state_nxt != r_state) begin
      r_wait <= '0;
    end else if (r_wait != 32'hFFFF_FFFF) begin
      r_wait <= r_wait + 32'd1;
    end
  end

  // Request capture and memory data path. For a byte store r_wdata first holds
  // the store data (its low byte feeds the merge), then the merged word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mw    <= MW_LOAD;
      r_lt    <= LT_W;
      r_lane  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_mw    <= memwrite;
        r_lt    <= ltype;
        r_lane  <= addr[1:0];
        r_addr  <= {addr[AW-1:2], 2'b00};
        r_wdata <= wdata;
      end
      if ((r_state == RD) && mem_ack) begin
        if (r_mw == MW_BYTE) begin
          r_wdata <= w_merge;
        end else begin
          r_rdata <= w_load;
        end
      end
    end
  end

  lsu_bytefmt u_fmt (
    .i_word  (mem_rdata),
    .i_lane  (r_lane),
    .i_ltype (r_lt),
    .i_byte  (r_wdata[7:0]),
    .o_load  (w_load),
    .o_merge (w_merge)
  );

  assign rdata     = r_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl with a transaction-level
// reference model and a memory responder with configurable ack delays.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  memwrite;
  logic [1:0]  ltype;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy, done, fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_ctrl #(.AW(32), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .memwrite  (memwrite),
    .ltype     (ltype),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: the model predicts completion cycle, fault, rdata and
  // write data; the loop plays memory, acking each phase after w1 (read) or
  // w2 (write) wait cycles. poke re-pulses start while busy.
  task automatic run_txn(input logic [1:0] mw, input logic [1:0] lt,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rw, input int w1, input int w2,
                         input bit poke, output int odone,
                         output logic [31:0] owaddr, output logic [31:0] owdata,
                         output bit osawreq);
    int t, exp_done, cnt, lane;
    bit exp_fault, exp_rd, exp_wr, exp_wok, misal, got, obs_fault;
    bit saw_rd, saw_wr, bad_busy, bad_addr, bad_fault, prev_req, prev_we;
    logic [31:0] exp_rdata, exp_wdata, exp_addr;
    logic [7:0]  b;

    lane      = int'(a[1:0]);
    exp_addr  = {a[31:2], 2'b00};
    b         = 8'((rw >> (8 * lane)) & 32'hFF);
    misal     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = (a[1:0] != 2'b00) && ((mw == 2'b01) || (mw == 2'b00 && lt == 2'b00));
`endif
    exp_fault = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_wok = 1'b0;
    exp_rdata = model_rdata; exp_wdata = 32'h0; exp_done = 0;
    if (mw == 2'b11 || lt == 2'b11 || misal) begin
      exp_fault = 1'b1;
      exp_done  = 1;
    end else begin
      t = 1;
      if (mw != 2'b01) begin
        exp_rd = 1'b1;
        if (w1 >= TO) begin exp_fault = 1'b1; exp_done = t + TO; end
        else t = t + w1 + 1;
      end
      if (!exp_fault && mw != 2'b00) begin
        exp_wr = 1'b1;
        if (w2 >= TO) begin
          exp_fault = 1'b1;
          exp_done  = t + TO;
        end else begin
          exp_wok  = 1'b1;
          exp_done = t + w2 + 1;
          if (mw == 2'b01) exp_wdata = wd;
          else exp_wdata = (rw & ~(32'hFF << (8 * lane))) | ({24'h0, wd[7:0]} << (8 * lane));
        end
      end else if (!exp_fault) begin
        exp_done = t;
        if (lt == 2'b00)      exp_rdata = rw;
        else if (lt == 2'b01) exp_rdata = {24'h0, b};
        else                  exp_rdata = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
        model_rdata = exp_rdata;
      end
    end

    memwrite = mw; ltype = lt; addr = a; wdata = wd; start = 1'b1; mem_ack = 1'b0;
    got = 1'b0; odone = 0; obs_fault = 1'b0; owaddr = 32'h0; owdata = 32'h0;
    saw_rd = 1'b0; saw_wr = 1'b0; bad_busy = 1'b0; bad_addr = 1'b0; bad_fault = 1'b0;
    prev_req = 1'b0; prev_we = 1'b0; cnt = 0;
    for (int c = 1; c <= 60 && !got; c++) begin
      tick();
      if (c == 1) begin
        start = poke; memwrite = 2'($urandom); ltype = 2'($urandom);
        addr = $urandom; wdata = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin got = 1'b1; odone = c; obs_fault = fault; end
      else if (fault) bad_fault = 1'b1;
      if (!busy) bad_busy = 1'b1;
      if (mem_req) begin
        if (mem_we) saw_wr = 1'b1; else saw_rd = 1'b1;
        if (mem_addr !== exp_addr) bad_addr = 1'b1;
        cnt = (prev_req && prev_we == mem_we) ? cnt + 1 : 0;
        mem_ack = (cnt == (mem_we ? w2 : w1));
        mem_rdata = mem_we ? $urandom : rw;
        if (mem_ack && mem_we) begin owaddr = mem_addr; owdata = mem_wdata; end
      end else begin
        cnt = 0;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
      end
      prev_req = mem_req;
      prev_we  = mem_we;
    end
    start = 1'b0;
    osawreq = saw_rd | saw_wr;

    checks++; if (!got || odone != exp_done) begin errors++; $display("FAIL done_cycle got %0d want %0d", odone, exp_done); end
    checks++; if (obs_fault !== exp_fault) begin errors++; $display("FAIL fault got %0b want %0b", obs_fault, exp_fault); end
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rdata got %h want %h", rdata, exp_rdata); end
    checks++; if (saw_rd !== exp_rd || saw_wr !== exp_wr) begin errors++; $display("FAIL phases got rd%0b wr%0b want rd%0b wr%0b", saw_rd, saw_wr, exp_rd, exp_wr); end
    checks++; if (bad_addr) begin errors++; $display("FAIL mem_addr wrong during request, want %h", exp_addr); end
    checks++; if (bad_busy || bad_fault) begin errors++; $display("FAIL busy_fault_flags got busy_drop %0b stray_fault %0b want 0 0", bad_busy, bad_fault); end
    if (exp_wok) begin
      checks++; if (owdata !== exp_wdata) begin errors++; $display("FAIL mem_wdata got %h want %h", owdata, exp_wdata); end
    end
    tick();
    mem_ack = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL back_to_idle got busy %b done %b req %b want 0 0 0", busy, done, mem_req); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; memwrite = 2'b00; ltype = 2'b00;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    #1;
    checks++; if ({busy, done, fault, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, fault, mem_req, mem_we}); end
    repeat (2) tick();
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", mem_addr, mem_wdata, rdata); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_loads();
    int od; logic [31:0] wa, wv; bit sr;
    run_txn(2'b00, 2'b00, 32'h10, 32'h0, 32'h8123_4567, 0, 0, 1'b0, od, wa, wv, sr);
    checks++; if (od != 2 || rdata !== 32'h8123_4567) begin errors++; $display("FAIL lw_direct got cyc %0d %h want 2 81234567", od, rdata); end
    run_txn(2'b00, 2'b10, 32'h13, 32'h0, 32'h8123_4567, 0, 0, 1'b0, od, wa, wv, sr);
    checks++; if (rdata !== 32'hFFFF_FF81) begin errors++; $display("FAIL lb_direct got %h want ffffff81", rdata); end
    run_txn(2'b00, 2'b01, 32'h13, 32'h0, 32'h8123_4567, 0, 0, 1'b0, od, wa, wv, sr);
    checks++; if (rdata !== 32'h0000_0081) begin errors++; $display("FAIL lbu_direct got %h want 00000081", rdata); end
  endtask

  task automatic test_stores();
    int od; logic [31:0] wa, wv; bit sr;
    run_txn(2'b10, 2'b00, 32'h11, 32'h0000_00AA, 32'h1122_3344, 0, 0, 1'b0, od, wa, wv, sr);
    checks++; if (od != 3 || wa !== 32'h10 || wv !== 32'h1122_AA44) begin errors++; $display("FAIL sb_direct got cyc %0d addr %h data %h want 3 10 1122aa44", od, wa, wv); end
    run_txn(2'b01, 2'b00, 32'h40, 32'hCAFE_F00D, 32'h0, 0, 3, 1'b1, od, wa, wv, sr);
    checks++; if (od != 5 || wv !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_wait got cyc %0d data %h want 5 cafef00d", od, wv); end
  endtask

  task automatic test_faults();
    int od; logic [31:0] wa, wv; bit sr;
    run_txn(2'b00, 2'b00, 32'h20, 32'h0, 32'h5A5A_1234, 0, 0, 1'b0, od, wa, wv, sr);
    run_txn(2'b00, 2'b00, 32'h24, 32'h0, 32'hDEAD_BEEF, 9, 0, 1'b0, od, wa, wv, sr);
    checks++; if (od != 1 + TO || rdata !== 32'h5A5A_1234) begin errors++; $display("FAIL timeout got cyc %0d rdata %h want %0d 5a5a1234", od, rdata, 1 + TO); end
    run_txn(2'b11, 2'b00, 32'h30, 32'h0, 32'h0, 0, 0, 1'b0, od, wa, wv, sr);
    checks++; if (od != 1 || sr) begin errors++; $display("FAIL illegal got cyc %0d req %0b want 1 0", od, sr); end
    run_txn(2'b00, 2'b00, 32'h12, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0, od, wa, wv, sr);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (od != 1 || sr) begin errors++; $display("FAIL misalign got cyc %0d req %0b want 1 0", od, sr); end
`else
    checks++; if (od != 2 || rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL misalign got cyc %0d rdata %h want 2 0badf00d", od, rdata); end
`endif
  endtask

  task automatic test_random();
    int od; logic [31:0] wa, wv; bit sr;
    logic [1:0] mw, lt;
    for (int i = 0; i < 40; i++) begin
      mw = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      lt = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
      run_txn(mw, lt, $urandom, $urandom, $urandom, int'($urandom % 6), int'($urandom % 6),
              1'($urandom), od, wa, wv, sr);
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    memwrite = 2'b00; ltype = 2'b00; addr = 32'h20; wdata = 32'h0; start = 1'b1; mem_ack = 1'b0;
    tick();
    start = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_rd_req got %b want 1", mem_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({busy, done, fault, mem_req, mem_we} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid got ctrl %b addr %h wd %h rd %h want 0", {busy, done, fault, mem_req, mem_we}, mem_addr, mem_wdata, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 32'h0;
    mem_ack = 1'b1; mem_rdata = $urandom;
    stray = 1'b0;
    repeat (3) begin tick(); if (busy || mem_req || done) stray = 1'b1; end
    mem_ack = 1'b0;
    checks++; if (stray) begin errors++; $display("FAIL no_resume got activity after reset want none"); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_random();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
